serial_comparator: RTL

//   Bit-serial magnitude comparator. Consumes two WIDTH-bit operands A and B one bit pair per beat, MSB first.

---
 rtl/cmp_pkg.sv | 28 ++
 rtl/comparator_1bit.sv | 13 +
 rtl/serial_comparator.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared encodings for the bit-serial comparator: FSM states and the
// 2-bit verdict code carried from the decide logic to the result flags.
package cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  // An undecided comparison after the final beat means every bit pair matched.
  function automatic logic [1:0] verdict(input logic decided, input logic gt,
                                         input logic lt);
    logic [1:0] code;
    code = RES_EQ;
    if (decided && gt) begin
      code = RES_GT;
    end else if (decided && lt) begin
      code = RES_LT;
    end
    return code;
  endfunction

endpackage

// File: rtl/comparator_1bit.sv
// Single-bit magnitude compare; purely combinational, one instance per
// serial lane.
module comparator_1bit (
  input  logic a_bit,
  input  logic b_bit,
  output logic A_gt_B,
  output logic A_lt_B
);

  assign A_gt_B = a_bit & ~b_bit;
  assign A_lt_B = ~a_bit & b_bit;

endmodule

// File: rtl/serial_comparator.sv
// MSB-first bit-serial magnitude comparator with valid/ready operand beats
// and a registered one-hot gt/lt/eq result on a valid/ready result port.
module serial_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  output logic             bit_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_count_reg, bit_count_next;
  logic             decided_reg, decided_next;
  logic             gt_reg, gt_next;
  logic             lt_reg, lt_next;
  logic             a_gt_b_reg, a_gt_b_next;
  logic             a_lt_b_reg, a_lt_b_next;
  logic             a_eq_b_reg, a_eq_b_next;
  logic             beat_gt, beat_lt;
  logic [1:0]       final_code;

  comparator_1bit u_cmp (
    .a_bit  (a_bit),
    .b_bit  (b_bit),
    .A_gt_B (beat_gt),
    .A_lt_B (beat_lt)
  );

  always_comb begin
    state_next     = state_reg;
    bit_count_next = bit_count_reg;
    decided_next   = decided_reg;
    gt_next        = gt_reg;
    lt_next        = lt_reg;
    a_gt_b_next    = a_gt_b_reg;
    a_lt_b_next    = a_lt_b_reg;
    a_eq_b_next    = a_eq_b_reg;
    final_code     = RES_EQ;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next     = S_COMPARE;
          bit_count_next = '0;
          decided_next   = 1'b0;
          gt_next        = 1'b0;
          lt_next        = 1'b0;
        end
      end

      S_COMPARE: begin
        if (bit_valid) begin
          bit_count_next = bit_count_reg + CNT_W'(1);
          // The first differing bit pair (MSB first) fixes the verdict.
          if (!decided_reg) begin
            if (beat_gt) begin
              decided_next = 1'b1;
              gt_next      = 1'b1;
            end else if (beat_lt) begin
              decided_next = 1'b1;
              lt_next      = 1'b1;
            end
          end
          if (bit_count_reg == CNT_W'(WIDTH - 1)) begin
            state_next  = S_DONE;
            final_code  = verdict(decided_next, gt_next, lt_next);
            a_gt_b_next = (final_code == RES_GT);
            a_lt_b_next = (final_code == RES_LT);
            a_eq_b_next = (final_code == RES_EQ);
          end
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_next  = S_IDLE;
          a_gt_b_next = 1'b0;
          a_lt_b_next = 1'b0;
          a_eq_b_next = 1'b0;
        end
      end

      default: begin
        state_next  = S_IDLE;
        a_gt_b_next = 1'b0;
        a_lt_b_next = 1'b0;
        a_eq_b_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      bit_count_reg <= '0;
      decided_reg   <= 1'b0;
      gt_reg        <= 1'b0;
      lt_reg        <= 1'b0;
      a_gt_b_reg    <= 1'b0;
      a_lt_b_reg    <= 1'b0;
      a_eq_b_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_count_reg <= bit_count_next;
      decided_reg   <= decided_next;
      gt_reg        <= gt_next;
      lt_reg        <= lt_next;
      a_gt_b_reg    <= a_gt_b_next;
      a_lt_b_reg    <= a_lt_b_next;
      a_eq_b_reg    <= a_eq_b_next;
    end
  end

  // Handshake outputs decode the state register only, so they stay glitch-free.
  assign bit_ready = (state_reg == S_COMPARE);
  assign res_valid = (state_reg == S_DONE);
  assign busy      = (state_reg != S_IDLE);
  assign bit_count = bit_count_reg;
  assign A_gt_B    = a_gt_b_reg;
  assign A_lt_B    = a_lt_b_reg;
  assign A_eq_B    = a_eq_b_reg;

endmodule
